// File: rtl/mem_dump_streamer.sv
// Streams a block of a byte-wide memory as little-endian 32-bit words over valid/ready.
// Each word takes four back-to-back byte reads, one wait cycle for the last byte, then a hold until accepted.
module mem_dump_streamer #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [31:0]       word_data,
    output logic [ADDR_W-1:0] word_addr,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WT,
        S_OUT,
        S_FIN
    } state_t;

    state_t            state, state_n;
    logic [1:0]        idx, idx_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] cur, cur_n;
    logic              pend, pend_n;
    logic [1:0]        pidx, pidx_n;

    logic              rd_en_n;
    logic [ADDR_W-1:0] addr_n;
    logic              valid_n;
    logic [31:0]       data_n;
    logic [ADDR_W-1:0] waddr_n;
    logic              busy_n;
    logic              done_n;
    logic              error_n;
    logic              kill;

    assign kill = abort && (state != S_IDLE);

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        cur_n   = cur;
        pend_n  = mem_rd_en;
        pidx_n  = mem_addr[1:0];
        rd_en_n = 1'b0;
        addr_n  = mem_addr;
        valid_n = word_valid;
        data_n  = word_data;
        waddr_n = word_addr;
        done_n  = 1'b0;
        error_n = 1'b0;

        // Byte lane is the low address bits of the read issued last cycle (base is word aligned).
        if (pend && !kill) begin
            data_n[{pidx, 3'b000} +: 8] = mem_rdata;
        end

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (base_addr[1:0] != 2'b00) begin
                        error_n = 1'b1;
                    end else if (num_words == CNT_W'(0)) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = S_RD;
                        cnt_n   = num_words;
                        cur_n   = base_addr;
                        idx_n   = 2'd0;
                        addr_n  = base_addr;
                        rd_en_n = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (idx == 2'd3) begin
                    state_n = S_WT;
                end else begin
                    idx_n   = idx + 2'd1;
                    rd_en_n = 1'b1;
                    addr_n  = cur + ADDR_W'(idx_n);
                end
            end
            S_WT: begin
                state_n = S_OUT;
                valid_n = 1'b1;
                waddr_n = cur;
            end
            S_OUT: begin
                if (word_ready) begin
                    valid_n = 1'b0;
                    cnt_n   = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_n = S_FIN;
                    end else begin
                        state_n = S_RD;
                        cur_n   = cur + ADDR_W'(4);
                        addr_n  = cur + ADDR_W'(4);
                        idx_n   = 2'd0;
                        rd_en_n = 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Abort overrides everything: drop reads in flight and suppress done.
        if (kill) begin
            state_n = S_IDLE;
            rd_en_n = 1'b0;
            valid_n = 1'b0;
            done_n  = 1'b0;
            pend_n  = 1'b0;
        end

        // busy stays high through the done pulse cycle.
        busy_n = (state_n != S_IDLE) || done_n;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            cnt        <= '0;
            cur        <= '0;
            pend       <= 1'b0;
            pidx       <= 2'd0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            cur        <= cur_n;
            pend       <= pend_n;
            pidx       <= pidx_n;
            mem_rd_en  <= rd_en_n;
            mem_addr   <= addr_n;
            word_valid <= valid_n;
            word_data  <= data_n;
            word_addr  <= waddr_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
        end
    end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer: byte memory model, event counters and
// immediate-assertion checks against hand-computed values.
module tb_mem_dump_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  num_words;
    logic        abort;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic [7:0]  word_addr;
    logic        busy;
    logic        done;
    logic        error;

    logic [7:0]  mem [256];
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          acc_cnt = 0;
    int          val_cnt = 0;
    int          rd0, dn0, er0, ac0, vl0;

    always #5 clk = ~clk;

    mem_dump_streamer #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .abort      (abort),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_addr  (word_addr),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Synchronous byte memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
        if (word_valid && word_ready) acc_cnt <= acc_cnt + 1;
        if (word_valid) val_cnt <= val_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        rd0 = rd_cnt; dn0 = done_cnt; er0 = err_cnt; ac0 = acc_cnt; vl0 = val_cnt;
    endtask

    // Issue a one-cycle start; returns positioned in cycle 1.
    task automatic kick(input logic [7:0] b, input logic [7:0] n);
        base_addr = b;
        num_words = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h50; mem[3] = 8'h00;
        mem[8]  = 8'hef; mem[9]  = 8'hbe; mem[10] = 8'had; mem[11] = 8'hde;
        mem[12] = 8'h78; mem[13] = 8'h56; mem[14] = 8'h34; mem[15] = 8'h12;
        mem[252] = 8'h01; mem[253] = 8'h02; mem[254] = 8'h03; mem[255] = 8'h04;
        rst = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; abort = 1'b0;
        word_ready = 1'b1;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_rden", 32'(mem_rd_en), 32'd0);
        chk("rst_data", word_data, 32'd0);
        rst = 1'b1;
        tick();

        // Test 1: single word, full latency profile.
        snap();
        kick(8'h00, 8'd1);
        chk("t1_c1_busy", 32'(busy), 32'd1);
        chk("t1_c1_rden", 32'(mem_rd_en), 32'd1);
        chk("t1_c1_addr", 32'(mem_addr), 32'd0);
        tick(); tick(); tick();
        chk("t1_c4_addr", 32'(mem_addr), 32'd3);
        tick();
        chk("t1_c5_valid", 32'(word_valid), 32'd0);
        chk("t1_c5_rden", 32'(mem_rd_en), 32'd0);
        tick();
        chk("t1_c6_valid", 32'(word_valid), 32'd1);
        chk("t1_c6_data", word_data, 32'h00500513);
        chk("t1_c6_waddr", 32'(word_addr), 32'd0);
        tick();
        chk("t1_c7_valid", 32'(word_valid), 32'd0);
        chk("t1_c7_done", 32'(done), 32'd0);
        tick();
        chk("t1_c8_done", 32'(done), 32'd1);
        chk("t1_c8_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_c9_done", 32'(done), 32'd0);
        chk("t1_c9_busy", 32'(busy), 32'd0);
        chk("t1_reads", 32'(rd_cnt - rd0), 32'd4);

        // Test 2: two words back to back.
        snap();
        kick(8'h08, 8'd2);
        repeat (5) tick();
        chk("t2_w0_valid", 32'(word_valid), 32'd1);
        chk("t2_w0_data", word_data, 32'hdeadbeef);
        chk("t2_w0_addr", 32'(word_addr), 32'd8);
        tick();
        chk("t2_c7_addr", 32'(mem_addr), 32'd12);
        repeat (5) tick();
        chk("t2_w1_valid", 32'(word_valid), 32'd1);
        chk("t2_w1_data", word_data, 32'h12345678);
        chk("t2_w1_addr", 32'(word_addr), 32'd12);
        tick(); tick();
        chk("t2_done", 32'(done), 32'd1);
        tick();
        chk("t2_reads", 32'(rd_cnt - rd0), 32'd8);
        chk("t2_acc", 32'(acc_cnt - ac0), 32'd2);

        // Test 3: sink stalls for 5 cycles.
        snap();
        word_ready = 1'b0;
        kick(8'h00, 8'd1);
        repeat (5) tick();
        chk("t3_c6_valid", 32'(word_valid), 32'd1);
        repeat (4) tick();
        chk("t3_c10_valid", 32'(word_valid), 32'd1);
        chk("t3_c10_data", word_data, 32'h00500513);
        chk("t3_c10_waddr", 32'(word_addr), 32'd0);
        chk("t3_c10_reads", 32'(rd_cnt - rd0), 32'd4);
        word_ready = 1'b1;
        tick();
        tick();
        chk("t3_c12_valid", 32'(word_valid), 32'd0);
        wait_idle("t3_idle");
        chk("t3_acc", 32'(acc_cnt - ac0), 32'd1);
        chk("t3_done", 32'(done_cnt - dn0), 32'd1);
        chk("t3_reads", 32'(rd_cnt - rd0), 32'd4);

        // Test 4: address wrap.
        snap();
        kick(8'hFC, 8'd2);
        repeat (5) tick();
        chk("t4_w0_data", word_data, 32'h04030201);
        chk("t4_w0_addr", 32'(word_addr), 32'hFC);
        tick();
        chk("t4_c7_addr", 32'(mem_addr), 32'h00);
        chk("t4_c7_rden", 32'(mem_rd_en), 32'd1);
        repeat (5) tick();
        chk("t4_w1_data", word_data, 32'h00500513);
        chk("t4_w1_addr", 32'(word_addr), 32'h00);
        wait_idle("t4_idle");

        // Test 5: misaligned start, zero length, start while busy.
        snap();
        kick(8'h02, 8'd1);
        chk("t5_err", 32'(error), 32'd1);
        chk("t5_err_busy", 32'(busy), 32'd0);
        tick();
        chk("t5_err_pulse", 32'(error), 32'd0);
        chk("t5_err_reads", 32'(rd_cnt - rd0), 32'd0);
        kick(8'h00, 8'd0);
        chk("t5_zero_done", 32'(done), 32'd1);
        tick();
        chk("t5_zero_pulse", 32'(done), 32'd0);
        chk("t5_zero_reads", 32'(rd_cnt - rd0), 32'd0);
        chk("t5_err_count", 32'(err_cnt - er0), 32'd1);
        snap();
        kick(8'h00, 8'd1);
        kick(8'h08, 8'd2);
        wait_idle("t5_busy_idle");
        chk("t5_busy_acc", 32'(acc_cnt - ac0), 32'd1);
        chk("t5_busy_reads", 32'(rd_cnt - rd0), 32'd4);
        chk("t5_busy_done", 32'(done_cnt - dn0), 32'd1);

        // Test 6a: abort during reads.
        snap();
        kick(8'h08, 8'd2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_busy", 32'(busy), 32'd0);
        chk("t6_abort_rden", 32'(mem_rd_en), 32'd0);
        repeat (8) tick();
        chk("t6_abort_valid", 32'(val_cnt - vl0), 32'd0);
        chk("t6_abort_done", 32'(done_cnt - dn0), 32'd0);
        chk("t6_abort_reads", 32'(rd_cnt - rd0), 32'd2);

        // Test 6b: reset while holding a word.
        snap();
        word_ready = 1'b0;
        kick(8'h08, 8'd1);
        repeat (5) tick();
        chk("t6_rst_pre", 32'(word_valid), 32'd1);
        rst = 1'b0;
        tick();
        chk("t6_rst_valid", 32'(word_valid), 32'd0);
        chk("t6_rst_data", word_data, 32'd0);
        chk("t6_rst_waddr", 32'(word_addr), 32'd0);
        chk("t6_rst_addr", 32'(mem_addr), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        word_ready = 1'b1;
        repeat (3) tick();
        chk("t6_rst_done", 32'(done_cnt - dn0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
